// File: rtl/pkt_wrr_arb.sv
// pkt_wrr_arb: 4-source weighted round-robin packet arbiter for AXI-Stream.
// One source at a time owns the output stream. A grant is held for whole
// TLAST-delimited packets, and a source may send up to WEIGHTn packets per
// turn before the grant rotates. The datapath is a pure combinational mux.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   srcN_TDATA/TVALID/TLAST   source N stream inputs (N = 0..3)
//   srcN_TREADY               source N ready (only the granted source sees it)
//   res_TDATA/TVALID/TLAST    output stream (zero when nothing is granted)
//   res_TREADY                output ready from the sink
//   gnt                       one-hot current grant, 0 in IDLE
//   dbg_state                 FSM state (0 IDLE, 1 BURST, 2 HOLD)
//   dbg_ptr                   rotation pointer (next source searched first)
//
// Handshake: a beat moves on the rising edge where TVALID and TREADY are both
// high. res_TVALID is a copy of the granted source's TVALID and never looks at
// res_TREADY; res_TREADY is forwarded combinationally to the granted source.
module pkt_wrr_arb #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter string       RESET_TYPE = "ACTIVE_HIGH",
  parameter int unsigned WEIGHT0    = 1,
  parameter int unsigned WEIGHT1    = 1,
  parameter int unsigned WEIGHT2    = 1,
  parameter int unsigned WEIGHT3    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] src0_TDATA,
  input  logic                  src0_TVALID,
  output logic                  src0_TREADY,
  input  logic                  src0_TLAST,
  input  logic [DATA_WIDTH-1:0] src1_TDATA,
  input  logic                  src1_TVALID,
  output logic                  src1_TREADY,
  input  logic                  src1_TLAST,
  input  logic [DATA_WIDTH-1:0] src2_TDATA,
  input  logic                  src2_TVALID,
  output logic                  src2_TREADY,
  input  logic                  src2_TLAST,
  input  logic [DATA_WIDTH-1:0] src3_TDATA,
  input  logic                  src3_TVALID,
  output logic                  src3_TREADY,
  input  logic                  src3_TLAST,
  output logic [DATA_WIDTH-1:0] res_TDATA,
  output logic                  res_TVALID,
  input  logic                  res_TREADY,
  output logic                  res_TLAST,
  output logic [3:0]            gnt,
  output logic [1:0]            dbg_state,
  output logic [1:0]            dbg_ptr
);

  if (RESET_TYPE != "ACTIVE_HIGH") begin : g_bad_reset_type
    $error("pkt_wrr_arb: only ACTIVE_HIGH synchronous reset is supported");
  end

  // Weight 0 behaves as 1; anything above the 4-bit credit range saturates.
  function automatic logic [3:0] eff_weight(input int unsigned w);
    if (w == 0)       return 4'd1;
    else if (w > 15)  return 4'd15;
    else              return w[3:0];
  endfunction

  localparam logic [3:0] WT0 = eff_weight(WEIGHT0);
  localparam logic [3:0] WT1 = eff_weight(WEIGHT1);
  localparam logic [3:0] WT2 = eff_weight(WEIGHT2);
  localparam logic [3:0] WT3 = eff_weight(WEIGHT3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      fsm_q, fsm_d;
  logic [1:0]  g_q, g_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  credit_q, credit_d;

  logic [DATA_WIDTH-1:0] s_data [4];
  logic [3:0]            s_valid;
  logic [3:0]            s_last;
  logic [3:0]            s_ready;

  logic [1:0]  pick;
  logic        pick_found;
  logic [1:0]  cand;
  logic [3:0]  pick_weight;
  logic        others_valid;

  assign s_data[0] = src0_TDATA;
  assign s_data[1] = src1_TDATA;
  assign s_data[2] = src2_TDATA;
  assign s_data[3] = src3_TDATA;
  assign s_valid   = {src3_TVALID, src2_TVALID, src1_TVALID, src0_TVALID};
  assign s_last    = {src3_TLAST, src2_TLAST, src1_TLAST, src0_TLAST};

  assign src0_TREADY = s_ready[0];
  assign src1_TREADY = s_ready[1];
  assign src2_TREADY = s_ready[2];
  assign src3_TREADY = s_ready[3];

  assign dbg_state = fsm_q;
  assign dbg_ptr   = ptr_q;

  // First valid source searching ptr, ptr+1, ... modulo 4.
  always_comb begin
    pick       = ptr_q;
    pick_found = 1'b0;
    cand       = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!pick_found && s_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    case (pick)
      2'd0:    pick_weight = WT0;
      2'd1:    pick_weight = WT1;
      2'd2:    pick_weight = WT2;
      default: pick_weight = WT3;
    endcase
  end

  assign others_valid = |(s_valid & ~(4'b0001 << g_q));

  always_comb begin
    fsm_d      = fsm_q;
    g_d        = g_q;
    ptr_d      = ptr_q;
    credit_d   = credit_q;
    gnt        = 4'b0000;
    res_TDATA  = '0;
    res_TVALID = 1'b0;
    res_TLAST  = 1'b0;
    s_ready    = 4'b0000;

    case (fsm_q)
      IDLE: begin
        if (pick_found) begin
          g_d      = pick;
          credit_d = pick_weight;
          fsm_d    = BURST;
        end
      end

      BURST, HOLD: begin
        gnt[g_q]     = 1'b1;
        res_TDATA    = s_data[g_q];
        res_TVALID   = s_valid[g_q];
        res_TLAST    = s_last[g_q];
        s_ready[g_q] = res_TREADY;

        if (fsm_q == HOLD && !s_valid[g_q]) begin
          // Between packets with nothing from the owner: give up the rest of
          // the turn only if someone else is waiting.
          if (others_valid) begin
            fsm_d = IDLE;
            ptr_d = g_q + 2'd1;
          end
        end else begin
          // Once the owner shows a beat we are inside a packet again; a
          // single-beat packet in HOLD resolves its TLAST outcome right here.
          fsm_d = BURST;
          if (s_valid[g_q] && res_TREADY && s_last[g_q]) begin
            if (credit_q <= 4'd1) begin
              fsm_d = IDLE;
              ptr_d = g_q + 2'd1;
            end else begin
              credit_d = credit_q - 4'd1;
              fsm_d    = HOLD;
            end
          end
        end
      end

      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= IDLE;
      g_q      <= 2'd0;
      ptr_q    <= 2'd0;
      credit_q <= 4'd0;
    end else begin
      fsm_q    <= fsm_d;
      g_q      <= g_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

endmodule

// File: tb/tb_pkt_wrr_arb.sv
// Testbench for pkt_wrr_arb. DUT weights: src0=1, src1=3, src2=1, src3=0
// (0 must act as 1). Sources are fed from per-source beat queues; the expected
// output order is pushed to exp_q by each scenario and checked beat by beat.
// Cycle timing: posedge+1 source drive, posedge+2 scenario drive,
// posedge+4 scenario checks, posedge+8 handshake sampling / scoreboard.
module tb_pkt_wrr_arb;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sd [4];
  logic [3:0] sv = 4'b0000;
  logic [3:0] sl = 4'b0000;
  wire  [3:0] sr;
  logic       res_tready = 1'b1;
  wire  [7:0] res_TDATA;
  wire        res_TVALID;
  wire        res_TLAST;
  wire  [3:0] gnt;
  wire  [1:0] dbg_state;
  wire  [1:0] dbg_ptr;

  logic [8:0] q0[$], q1[$], q2[$], q3[$];
  logic [8:0] exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  pkt_wrr_arb #(
    .DATA_WIDTH(8), .RESET_TYPE("ACTIVE_HIGH"),
    .WEIGHT0(1), .WEIGHT1(3), .WEIGHT2(1), .WEIGHT3(0)
  ) dut (
    .clk(clk), .rst(rst),
    .src0_TDATA(sd[0]), .src0_TVALID(sv[0]), .src0_TREADY(sr[0]), .src0_TLAST(sl[0]),
    .src1_TDATA(sd[1]), .src1_TVALID(sv[1]), .src1_TREADY(sr[1]), .src1_TLAST(sl[1]),
    .src2_TDATA(sd[2]), .src2_TVALID(sv[2]), .src2_TREADY(sr[2]), .src2_TLAST(sl[2]),
    .src3_TDATA(sd[3]), .src3_TVALID(sv[3]), .src3_TREADY(sr[3]), .src3_TLAST(sl[3]),
    .res_TDATA(res_TDATA), .res_TVALID(res_TVALID), .res_TREADY(res_tready),
    .res_TLAST(res_TLAST), .gnt(gnt), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [7:0] bdat(input int src, input int seq);
    return {6'(seq), 2'(src)};
  endfunction

  task automatic push_pkt(input int src, input int nbeats, input int seq0);
    logic [8:0] b;
    for (int i = 0; i < nbeats; i++) begin
      b = {(i == nbeats - 1), bdat(src, seq0 + i)};
      case (src)
        0:       q0.push_back(b);
        1:       q1.push_back(b);
        2:       q2.push_back(b);
        default: q3.push_back(b);
      endcase
    end
  endtask

  task automatic expect_pkt(input int src, input int nbeats, input int seq0);
    for (int i = 0; i < nbeats; i++)
      exp_q.push_back({(i == nbeats - 1), bdat(src, seq0 + i)});
  endtask

  // ---------------- source driver + scoreboard ----------------
  initial begin : src_bfm
    logic [8:0] got;
    logic [8:0] exp;
    for (int n = 0; n < 4; n++) sd[n] = 8'h00;
    forever begin
      @(posedge clk); #1;
      sv[0] = (q0.size() > 0); {sl[0], sd[0]} = (q0.size() > 0) ? q0[0] : 9'd0;
      sv[1] = (q1.size() > 0); {sl[1], sd[1]} = (q1.size() > 0) ? q1[0] : 9'd0;
      sv[2] = (q2.size() > 0); {sl[2], sd[2]} = (q2.size() > 0) ? q2[0] : 9'd0;
      sv[3] = (q3.size() > 0); {sl[3], sd[3]} = (q3.size() > 0) ? q3[0] : 9'd0;
      #7;
      if (sv[0] && sr[0]) void'(q0.pop_front());
      if (sv[1] && sr[1]) void'(q1.pop_front());
      if (sv[2] && sr[2]) void'(q2.pop_front());
      if (sv[3] && sr[3]) void'(q3.pop_front());
      if (res_TVALID && res_tready) begin
        got = {res_TLAST, res_TDATA};
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_extra: got beat %h, no beat expected", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            tests_failed++;
            $display("FAIL sb_beat: got {last,data}=%h expected %h", got, exp);
          end
        end
      end
    end
  end

  // Waits for all traffic to drain and the FSM to return to IDLE.
  task automatic wait_idle(input string tag);
    int  n    = 0;
    bit  done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk); #4;
      n++;
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
          q2.size() == 0 && q3.size() == 0 && dbg_state == ST_IDLE)
        done = 1'b1;
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d beats outstanding, state %0d, required 0 and IDLE",
               tag, exp_q.size(), dbg_state);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      push_pkt(n, 1, 0);
      expect_pkt(n, 1, 0);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #4;
      tests_run++;
      if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
      tests_run++;
      if (res_TVALID !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b expected 0", res_TVALID); end
      tests_run++;
      if (sr !== 4'b0000) begin tests_failed++; $display("FAIL rst_tready: got %b expected 0000", sr); end
      tests_run++;
      if (dbg_state !== ST_IDLE || dbg_ptr !== 2'd0) begin
        tests_failed++;
        $display("FAIL rst_state: got state %0d ptr %0d expected 0 0", dbg_state, dbg_ptr);
      end
    end
    rst = 1'b0;
    @(posedge clk); #4;
    tests_run++;
    if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL rst_first_gnt: got %b expected 0001", gnt); end
  endtask

  task automatic test_single_source();
    @(posedge clk); #2;
    push_pkt(2, 3, 0);
    expect_pkt(2, 3, 0);
    @(posedge clk); #4;
    tests_run++;
    if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL single_idle_gnt: got %b expected 0000", gnt); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #4;
      tests_run++;
      if (gnt !== 4'b0100) begin tests_failed++; $display("FAIL single_gnt beat%0d: got %b expected 0100", i, gnt); end
      tests_run++;
      if (res_TVALID !== 1'b1 || res_TDATA !== bdat(2, i) || res_TLAST !== (i == 2)) begin
        tests_failed++;
        $display("FAIL single_beat%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 i, res_TVALID, res_TDATA, res_TLAST, bdat(2, i), (i == 2));
      end
    end
    @(posedge clk); #4;
    tests_run++;
    if (gnt !== 4'b0000 || dbg_state !== ST_IDLE || dbg_ptr !== 2'd3) begin
      tests_failed++;
      $display("FAIL single_release: got gnt %b state %0d ptr %0d expected 0000 0 3", gnt, dbg_state, dbg_ptr);
    end
  endtask

  // Weight-1 sources 0,2,3 with ptr=3: src1 is skipped without compensation.
  task automatic test_fair_rotation();
    int         ord [6];
    logic [3:0] exp_gnt;
    ord[0] = 3; ord[1] = 0; ord[2] = 2; ord[3] = 3; ord[4] = 0; ord[5] = 2;
    @(posedge clk); #2;
    for (int k = 0; k < 6; k++) begin
      push_pkt(ord[k], 2, (k < 3) ? 0 : 2);
      expect_pkt(ord[k], 2, (k < 3) ? 0 : 2);
    end
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < 3; p++) begin
        @(posedge clk); #4;
        exp_gnt = (p == 0) ? 4'b0000 : (4'b0001 << ord[k]);
        tests_run++;
        if (gnt !== exp_gnt || res_TVALID !== (p != 0)) begin
          tests_failed++;
          $display("FAIL rot k%0d p%0d: got gnt %b valid %b expected %b %b",
                   k, p, gnt, res_TVALID, exp_gnt, (p != 0));
        end
      end
    end
  endtask

  // ptr=3: order src3, src0, src1 x3 back to back, src2.
  task automatic test_weighting();
    int         seg_src [4];
    int         seg_len [4];
    logic [3:0] exp_gnt;
    seg_src[0] = 3; seg_src[1] = 0; seg_src[2] = 1; seg_src[3] = 2;
    seg_len[0] = 2; seg_len[1] = 2; seg_len[2] = 6; seg_len[3] = 2;
    @(posedge clk); #2;
    push_pkt(0, 2, 8); push_pkt(2, 2, 8); push_pkt(3, 2, 8);
    push_pkt(1, 2, 8); push_pkt(1, 2, 10); push_pkt(1, 2, 12);
    expect_pkt(3, 2, 8); expect_pkt(0, 2, 8);
    expect_pkt(1, 2, 8); expect_pkt(1, 2, 10); expect_pkt(1, 2, 12);
    expect_pkt(2, 2, 8);
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p <= seg_len[s]; p++) begin
        @(posedge clk); #4;
        exp_gnt = (p == 0) ? 4'b0000 : (4'b0001 << seg_src[s]);
        tests_run++;
        if (gnt !== exp_gnt || res_TVALID !== (p != 0)) begin
          tests_failed++;
          $display("FAIL wrr s%0d p%0d: got gnt %b valid %b expected %b %b",
                   s, p, gnt, res_TVALID, exp_gnt, (p != 0));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #2;
    push_pkt(0, 4, 1);
    expect_pkt(0, 4, 1); expect_pkt(1, 1, 20); expect_pkt(2, 1, 20); expect_pkt(3, 1, 20);
    @(posedge clk); #4;
    tests_run++;
    if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL bp_idle: got %b expected 0000", gnt); end
    @(posedge clk); #2;
    push_pkt(1, 1, 20); push_pkt(2, 1, 20); push_pkt(3, 1, 20);
    #2;
    tests_run++;
    if (gnt !== 4'b0001 || res_TDATA !== bdat(0, 1)) begin
      tests_failed++;
      $display("FAIL bp_first: got gnt %b data %h expected 0001 %h", gnt, res_TDATA, bdat(0, 1));
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      res_tready = 1'b0;
      #2;
      tests_run++;
      if (gnt !== 4'b0001 || res_TDATA !== bdat(0, 2) || res_TVALID !== 1'b1 || sr !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bp_stall%0d: got gnt %b data %h valid %b tready %b expected 0001 %h 1 0000",
                 i, gnt, res_TDATA, res_TVALID, sr, bdat(0, 2));
      end
    end
    @(posedge clk); #2;
    res_tready = 1'b1;
    #2;
    tests_run++;
    if (sr !== 4'b0001 || res_TDATA !== bdat(0, 2)) begin
      tests_failed++;
      $display("FAIL bp_resume: got tready %b data %h expected 0001 %h", sr, res_TDATA, bdat(0, 2));
    end
  endtask

  // src1 (weight 3) sends one packet, then only src3 is waiting.
  task automatic test_hold_release();
    @(posedge clk); #2;
    push_pkt(1, 2, 30); push_pkt(3, 1, 30);
    expect_pkt(1, 2, 30); expect_pkt(3, 1, 30);
    @(posedge clk); #4;
    @(posedge clk); #4;
    tests_run++;
    if (gnt !== 4'b0010) begin tests_failed++; $display("FAIL hr_gnt: got %b expected 0010", gnt); end
    @(posedge clk); #4;
    @(posedge clk); #4;
    tests_run++;
    if (dbg_state !== ST_HOLD || gnt !== 4'b0010 || res_TVALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL hr_hold: got state %0d gnt %b valid %b expected 2 0010 0", dbg_state, gnt, res_TVALID);
    end
    @(posedge clk); #4;
    tests_run++;
    if (dbg_state !== ST_IDLE || dbg_ptr !== 2'd2 || gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL hr_release: got state %0d ptr %0d gnt %b expected 0 2 0000", dbg_state, dbg_ptr, gnt);
    end
    @(posedge clk); #4;
    tests_run++;
    if (gnt !== 4'b1000) begin tests_failed++; $display("FAIL hr_next: got %b expected 1000", gnt); end
  endtask

  // Credit counting through HOLD with single-beat packets and an idle gap.
  task automatic test_hold_credit();
    @(posedge clk); #2;
    push_pkt(1, 1, 40);
    expect_pkt(1, 1, 40); expect_pkt(1, 1, 41); expect_pkt(1, 1, 42);
    @(posedge clk); #4;
    @(posedge clk); #4;
    tests_run++;
    if (gnt !== 4'b0010 || res_TVALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL hc_first: got gnt %b valid %b expected 0010 1", gnt, res_TVALID);
    end
    @(posedge clk); #4;
    @(posedge clk); #2;
    push_pkt(1, 1, 41); push_pkt(1, 1, 42);
    #2;
    tests_run++;
    if (dbg_state !== ST_HOLD || gnt !== 4'b0010 || res_TVALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL hc_wait: got state %0d gnt %b valid %b expected 2 0010 0", dbg_state, gnt, res_TVALID);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #4;
      tests_run++;
      if (dbg_state !== ST_HOLD || res_TVALID !== 1'b1 || sr !== 4'b0010) begin
        tests_failed++;
        $display("FAIL hc_hold_beat%0d: got state %0d valid %b tready %b expected 2 1 0010",
                 i, dbg_state, res_TVALID, sr);
      end
    end
    @(posedge clk); #4;
    tests_run++;
    if (dbg_state !== ST_IDLE || dbg_ptr !== 2'd2 || gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL hc_release: got state %0d ptr %0d gnt %b expected 0 2 0000", dbg_state, dbg_ptr, gnt);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();          wait_idle("reset");
    test_single_source();  wait_idle("single");
    test_fair_rotation();  wait_idle("rotation");
    test_weighting();      wait_idle("weighting");
    test_backpressure();   wait_idle("backpressure");
    test_hold_release();   wait_idle("hold_release");
    test_hold_credit();    wait_idle("hold_credit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
